// File: rtl/mem_byte_bridge_pkg.sv
// Shared types and constants for the byte-wide memory bridge.
package mem_byte_bridge_pkg;

  localparam int BYTE          = 8;
  localparam int MEM_ADDR_SIZE = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    DRAIN
  } bridge_state_t;

endpackage

// File: rtl/mem_byte_bridge_if.sv
// Core-side and memory-side signals of the byte bridge; slave is the bridge's view.
interface mem_byte_bridge_if #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MAX_BYTES = 3
);

  // Core side
  logic                     req_i;
  logic [ADDR_W-1:0]        addr_i;
  logic [1:0]               nbytes_i;
  logic                     we_i;
  logic [7:0]               wdata_i;
  logic                     flush_i;
  logic                     rdy_o;
  logic                     busy_o;
  logic                     valid_o;
  logic [8*MAX_BYTES-1:0]   data_o;

  // Memory side
  logic                     mem_req_o;
  logic [ADDR_W-1:0]        mem_addr_o;
  logic                     mem_we_o;
  logic [7:0]               mem_wdata_o;
  logic                     mem_gnt_i;
  logic                     mem_rvalid_i;
  logic [7:0]               mem_rdata_i;

  modport slave (
    input  req_i, addr_i, nbytes_i, we_i, wdata_i, flush_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output rdy_o, busy_o, valid_o, data_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o
  );

  modport master (
    output req_i, addr_i, nbytes_i, we_i, wdata_i, flush_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  rdy_o, busy_o, valid_o, data_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o
  );

endinterface

// File: rtl/mem_byte_bridge.sv
// Splits a 1-3 byte read or a 1-byte write into sequential byte accesses on a
// request/grant memory bus and assembles read bytes little-endian.
module mem_byte_bridge
  import mem_byte_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W    = MEM_ADDR_SIZE,
  parameter int unsigned MAX_BYTES = 3
) (
  input logic               clk_i,
  input logic               rstn_i,
  mem_byte_bridge_if.slave  bus
);

  localparam int unsigned DATA_W = BYTE * MAX_BYTES;

  bridge_state_t     r_state, w_state_d;
  logic [ADDR_W-1:0] r_base, w_base_d;
  logic [1:0]        r_n, w_n_d;
  logic [1:0]        r_idx, w_idx_d;
  logic              r_we, w_we_d;
  logic [7:0]        r_wdata, w_wdata_d;
  logic [DATA_W-1:0] r_data, w_data_d;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_n     <= 2'd1;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_d;
      r_base  <= w_base_d;
      r_n     <= w_n_d;
      r_idx   <= w_idx_d;
      r_we    <= w_we_d;
      r_wdata <= w_wdata_d;
      r_data  <= w_data_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_base_d  = r_base;
    w_n_d     = r_n;
    w_idx_d   = r_idx;
    w_we_d    = r_we;
    w_wdata_d = r_wdata;
    w_data_d  = r_data;

    unique case (r_state)
      IDLE: begin
        // flush_i blocks acceptance even though there is nothing to abort
        if (bus.req_i && !bus.flush_i) begin
          w_base_d  = bus.addr_i;
          w_we_d    = bus.we_i;
          w_wdata_d = bus.wdata_i;
          w_n_d     = (bus.we_i || bus.nbytes_i == 2'd0) ? 2'd1 : bus.nbytes_i;
          w_idx_d   = '0;
          w_data_d  = '0;
          w_state_d = REQ;
        end
      end

      REQ: begin
        if (bus.mem_gnt_i) begin
          if (r_we) w_state_d = bus.flush_i ? IDLE : DONE;
          else      w_state_d = bus.flush_i ? DRAIN : WAIT;
        end else if (bus.flush_i) begin
          w_state_d = IDLE;
        end
      end

      WAIT: begin
        if (bus.flush_i) begin
          // A granted read still owes us one response; swallow it in DRAIN
          w_state_d = bus.mem_rvalid_i ? IDLE : DRAIN;
        end else if (bus.mem_rvalid_i) begin
          w_data_d[BYTE*r_idx +: BYTE] = bus.mem_rdata_i;
          if (r_idx == r_n - 2'd1) begin
            w_state_d = DONE;
          end else begin
            w_idx_d   = r_idx + 2'd1;
            w_state_d = REQ;
          end
        end
      end

      DONE: w_state_d = IDLE;

      DRAIN: begin
        if (bus.mem_rvalid_i) w_state_d = IDLE;
      end

      default: w_state_d = IDLE;
    endcase
  end

  assign bus.rdy_o       = (r_state == IDLE);
  assign bus.busy_o      = (r_state != IDLE);
  assign bus.valid_o     = (r_state == DONE);
  assign bus.data_o      = r_data;
  assign bus.mem_req_o   = (r_state == REQ);
  assign bus.mem_addr_o  = r_base + ADDR_W'(r_idx);
  assign bus.mem_we_o    = (r_state == REQ) && r_we;
  assign bus.mem_wdata_o = r_wdata;

endmodule

// File: tb/tb_mem_byte_bridge.sv
// Scoreboard bench for mem_byte_bridge: a memory responder model, a monitor
// that checks every access and completion against queued expectations.
module tb_mem_byte_bridge;

  localparam int unsigned AW = 16;
  localparam int unsigned MB = 3;

  typedef struct {
    logic [23:0] data;
    int          t0;
    int          lat;
  } exp_rsp_t;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } exp_acc_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_byte_bridge_if #(.ADDR_W(AW), .MAX_BYTES(MB)) bus ();

  mem_byte_bridge #(.ADDR_W(AW), .MAX_BYTES(MB)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  exp_rsp_t   rsp_q[$];
  exp_acc_t   acc_q[$];
  logic [7:0] mem[int];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gnt_delay = 0;
  int rsp_delay = 0;
  bit stray = 1'b0;
  int n_gnt = 0;
  int req_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: grant after gnt_delay request cycles, rvalid rsp_delay cycles later
  initial begin
    int          wait_cnt;
    bit          pend;
    int          pend_cnt;
    logic [15:0] pend_addr;
    wait_cnt = 0;
    pend = 1'b0;
    pend_cnt = 0;
    pend_addr = '0;
    bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      bus.mem_gnt_i = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i = '0;
      if (!rstn) begin
        wait_cnt = 0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (pend_cnt == 0) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i = mem.exists(int'(pend_addr)) ? mem[int'(pend_addr)] : 8'h00;
            pend = 1'b0;
          end else begin
            pend_cnt--;
          end
        end else if (stray) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i = 8'hEE;
          stray = 1'b0;
        end
        if (bus.mem_req_o) begin
          if (wait_cnt < gnt_delay) begin
            wait_cnt++;
          end else begin
            bus.mem_gnt_i = 1'b1;
            wait_cnt = 0;
            n_gnt++;
            if (bus.mem_we_o) begin
              mem[int'(bus.mem_addr_o)] = bus.mem_wdata_o;
            end else begin
              pend = 1'b1;
              pend_cnt = rsp_delay;
              pend_addr = bus.mem_addr_o;
            end
          end
        end
      end
    end
  end

  // Monitor: compares every request cycle and every completion pulse
  initial begin
    exp_acc_t a;
    exp_rsp_t r;
    forever begin
      @(negedge clk);
      #2;
      if (rstn) begin
        if (bus.mem_req_o) begin
          req_cycles++;
          checks++;
          if (acc_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_access: got addr %h we %b, required no access",
                     bus.mem_addr_o, bus.mem_we_o);
          end else begin
            a = acc_q[0];
            if (bus.mem_addr_o !== a.addr || bus.mem_we_o !== a.we ||
                bus.mem_wdata_o !== a.wdata) begin
              errors++;
              $display("FAIL access: got addr %h we %b wdata %h, required addr %h we %b wdata %h",
                       bus.mem_addr_o, bus.mem_we_o, bus.mem_wdata_o, a.addr, a.we, a.wdata);
            end
            if (bus.mem_gnt_i) void'(acc_q.pop_front());
          end
        end
        if (bus.valid_o) begin
          checks++;
          if (rsp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: got valid_o with data %h, required no pulse",
                     bus.data_o);
          end else begin
            r = rsp_q.pop_front();
            if (bus.data_o !== r.data || (cyc - r.t0) != r.lat) begin
              errors++;
              $display("FAIL completion: got data %h at cycle %0d, required data %h at cycle %0d",
                       bus.data_o, cyc - r.t0, r.data, r.lat);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_rdy",   32'(bus.rdy_o),       32'd1);
    check("rst_busy",  32'(bus.busy_o),      32'd0);
    check("rst_valid", 32'(bus.valid_o),     32'd0);
    check("rst_data",  32'(bus.data_o),      32'd0);
    check("rst_req",   32'(bus.mem_req_o),   32'd0);
    check("rst_we",    32'(bus.mem_we_o),    32'd0);
    check("rst_addr",  32'(bus.mem_addr_o),  32'd0);
    check("rst_wdata", 32'(bus.mem_wdata_o), 32'd0);
  endtask

  task automatic issue(input logic [15:0] a, input logic [1:0] nb, input logic we,
                       input logic [7:0] wd, input int n_acc, input logic [23:0] exp_data,
                       input int lat, input bit expect_rsp);
    int guard;
    guard = 0;
    @(negedge clk);
    #1;
    while (!bus.rdy_o && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout: got rdy_o 0 for 50 cycles, required 1");
      return;
    end
    bus.req_i = 1'b1;
    bus.addr_i = a;
    bus.nbytes_i = nb;
    bus.we_i = we;
    bus.wdata_i = wd;
    for (int i = 0; i < n_acc; i++) acc_q.push_back('{a + 16'(i), we, wd});
    if (expect_rsp) rsp_q.push_back('{exp_data, cyc, lat});
    @(negedge clk);
    #1;
    bus.req_i = 1'b0;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while ((rsp_q.size() != 0 || acc_q.size() != 0 || !bus.rdy_o) && guard < 100) begin
      @(negedge clk);
      #3;
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d responses pending, required 0", rsp_q.size());
      rsp_q.delete();
      acc_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100us, required finish");
    $fatal(1);
  end

  initial begin
    int g;
    int rc;
    int guard;
    bus.req_i = 1'b0;
    bus.addr_i = '0;
    bus.nbytes_i = '0;
    bus.we_i = 1'b0;
    bus.wdata_i = '0;
    bus.flush_i = 1'b0;
    mem[32'h8000] = 8'hA9; mem[32'h8001] = 8'h42; mem[32'h8002] = 8'h00;
    mem[32'hFFFF] = 8'h11; mem[32'h0000] = 8'h22;
    mem[32'h1000] = 8'h01; mem[32'h1001] = 8'h02; mem[32'h1002] = 8'h03;
    mem[32'h4000] = 8'h7E; mem[32'h4001] = 8'h99;
    mem[32'h3000] = 8'hC3;

    repeat (3) @(negedge clk);
    #1;
    check_reset_values();
    rstn = 1'b1;

    // 3-byte read, immediate grant: valid in cycle 7
    issue(16'h8000, 2'd3, 1'b0, 8'h00, 3, 24'h0042A9, 7, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);
    #1;
    check("data_hold", 32'(bus.data_o), 32'h0042A9);

    // Address wrap 0xFFFF -> 0x0000
    issue(16'hFFFF, 2'd2, 1'b0, 8'h00, 2, 24'h002211, 5, 1'b1);
    wait_done();

    // Write with grant held off 3 cycles; nbytes_i ignored
    gnt_delay = 3;
    rc = req_cycles;
    issue(16'h0200, 2'd3, 1'b1, 8'h5A, 1, 24'h000000, 5, 1'b1);
    wait_done();
    check("write_req_cycles", 32'(req_cycles - rc), 32'd4);
    check("write_mem", 32'(mem.exists(32'h0200) ? mem[32'h0200] : 8'h00), 32'h5A);
    gnt_delay = 0;

    // Flush in WAIT of the second byte: DRAIN swallows the late response
    rsp_delay = 2;
    g = n_gnt;
    issue(16'h1000, 2'd3, 1'b0, 8'h00, 2, 24'h0, 0, 1'b0);
    guard = 0;
    while (n_gnt < g + 2 && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("flush_reached_byte1", 32'(n_gnt - g), 32'd2);
    @(negedge clk);
    #1;
    bus.flush_i = 1'b1;
    @(negedge clk);
    #1;
    bus.flush_i = 1'b0;
    rsp_delay = 0;
    check("drain_busy", 32'(bus.busy_o), 32'd1);
    check("drain_not_rdy", 32'(bus.rdy_o), 32'd0);
    wait_done();
    issue(16'h1000, 2'd3, 1'b0, 8'h00, 3, 24'h030201, 7, 1'b1);
    wait_done();

    // nbytes_i = 0 means a single byte
    issue(16'h4000, 2'd0, 1'b0, 8'h00, 1, 24'h00007E, 3, 1'b1);
    wait_done();

    // Reset mid-REQ, then a stray response while idle
    gnt_delay = 1000;
    issue(16'h3000, 2'd1, 1'b0, 8'h00, 1, 24'h0, 0, 1'b0);
    @(negedge clk);
    #1;
    check("in_req_before_reset", 32'(bus.mem_req_o), 32'd1);
    rstn = 1'b0;
    #1;
    check_reset_values();
    acc_q.delete();
    gnt_delay = 0;
    @(negedge clk);
    #1;
    rstn = 1'b1;
    stray = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("stray_rdy", 32'(bus.rdy_o), 32'd1);
    check("stray_data", 32'(bus.data_o), 32'd0);
    issue(16'h3000, 2'd1, 1'b0, 8'h00, 1, 24'h0000C3, 3, 1'b1);
    wait_done();

    check("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    check("acc_q_empty", 32'(acc_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
